// File: rtl/vx_dp_ram_arbiter_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
// Optional perf counters are enabled by defining VX_DP_RAM_ARB_PERF_EN.
package vx_dp_ram_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int PERF_CNTW = 32;

    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Enough response credits to cover the read pipeline plus one slot of slack.
    function automatic int rsp_depth(input int out_reg);
        return 2 + out_reg;
    endfunction

endpackage

// File: rtl/vx_dp_ram_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester at or after the pointer;
// the pointer only advances past the winner when the grant is accepted.
module vx_dp_ram_arbiter_rr_arbiter
    import vx_dp_ram_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int REQ_SELW = log2up(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] valid,
    input  logic                accept,
    output logic                grant_valid,
    output logic [REQ_SELW-1:0] grant_idx
);

    logic [REQ_SELW-1:0] ptr;
    logic [REQ_SELW-1:0] cand;

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            cand = REQ_SELW'((int'(ptr) + i) % NUM_REQS);
            if (valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/vx_dp_ram_arbiter.sv
// Shares one 1W/1R RAM between NUM_REQS writers and NUM_REQS readers, with
// credit-based response buffering. Define VX_DP_RAM_ARB_PERF_EN for stall counters.
module vx_dp_ram_arbiter
    import vx_dp_ram_arbiter_pkg::*;
#(
    parameter int NUM_REQS       = 4,
    parameter int DATAW          = 32,
    parameter int SIZE           = 64,
    parameter int WRENW          = 4,
    parameter int OUT_REG        = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [DATAW-1:0] CLEAR_VALUE = '0,
    parameter int ADDRW          = log2up(SIZE),
    parameter int REQ_SELW       = log2up(NUM_REQS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          wr_valid_in,
    input  logic [NUM_REQS*ADDRW-1:0]    wr_addr_in,
    input  logic [NUM_REQS*DATAW-1:0]    wr_data_in,
    input  logic [NUM_REQS*WRENW-1:0]    wr_wren_in,
    output logic [NUM_REQS-1:0]          wr_ready_out,
    input  logic [NUM_REQS-1:0]          rd_valid_in,
    input  logic [NUM_REQS*ADDRW-1:0]    rd_addr_in,
    output logic [NUM_REQS-1:0]          rd_ready_out,
    output logic                         rsp_valid_out,
    output logic [DATAW-1:0]             rsp_data_out,
    output logic [REQ_SELW-1:0]          rsp_idx_out,
    input  logic                         rsp_ready_in,
    output logic                         ram_write,
    output logic [WRENW-1:0]             ram_wren,
    output logic [ADDRW-1:0]             ram_waddr,
    output logic [DATAW-1:0]             ram_wdata,
    output logic                         ram_read,
    output logic [ADDRW-1:0]             ram_raddr,
    input  logic [DATAW-1:0]             ram_rdata,
`ifdef VX_DP_RAM_ARB_PERF_EN
    output logic [PERF_CNTW-1:0]         perf_wr_stalls_out,
    output logic [PERF_CNTW-1:0]         perf_rd_stalls_out,
`endif
    output logic                         init_done_out
);

    localparam int RSP_DEPTH = rsp_depth(OUT_REG);
    localparam int CNTW      = log2up(RSP_DEPTH + 1);
    localparam int FIFO_AW   = log2up(RSP_DEPTH);

    state_t              state;
    logic [ADDRW-1:0]    clear_cnt;
    logic                run;

    logic                wr_cand_valid;
    logic [REQ_SELW-1:0] wr_cand_idx;
    logic                rd_cand_valid;
    logic [REQ_SELW-1:0] rd_cand_idx;
    logic                wr_fire;
    logic                rd_fire;
    logic                hazard;
    logic                credit_ok;

    logic [ADDRW-1:0]    wr_addr_sel;
    logic [DATAW-1:0]    wr_data_sel;
    logic [WRENW-1:0]    wr_wren_sel;
    logic [ADDRW-1:0]    rd_addr_sel;

    logic [CNTW-1:0]     inflight;
    logic [CNTW-1:0]     fifo_count;
    logic [CNTW:0]       credit_used;
    logic [FIFO_AW-1:0]  fifo_rd_ptr;
    logic [FIFO_AW-1:0]  fifo_wr_ptr;
    logic [DATAW-1:0]    fifo_data [RSP_DEPTH];
    logic [REQ_SELW-1:0] fifo_idx  [RSP_DEPTH];

    logic                push_valid;
    logic [REQ_SELW-1:0] push_idx;
    logic                pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clear_cnt     <= '0;
            init_done_out <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clear_cnt == ADDRW'(SIZE - 1)) begin
                        state         <= ST_RUN;
                        init_done_out <= 1'b1;
                    end else begin
                        clear_cnt <= clear_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done_out <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    assign run = (state == ST_RUN) && !reset;

    vx_dp_ram_arbiter_rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .REQ_SELW (REQ_SELW)
    ) wr_arb (
        .clk         (clk),
        .reset       (reset),
        .valid       (wr_valid_in),
        .accept      (wr_fire),
        .grant_valid (wr_cand_valid),
        .grant_idx   (wr_cand_idx)
    );

    vx_dp_ram_arbiter_rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .REQ_SELW (REQ_SELW)
    ) rd_arb (
        .clk         (clk),
        .reset       (reset),
        .valid       (rd_valid_in),
        .accept      (rd_fire),
        .grant_valid (rd_cand_valid),
        .grant_idx   (rd_cand_idx)
    );

    assign wr_addr_sel = wr_addr_in[int'(wr_cand_idx)*ADDRW +: ADDRW];
    assign wr_data_sel = wr_data_in[int'(wr_cand_idx)*DATAW +: DATAW];
    assign wr_wren_sel = wr_wren_in[int'(wr_cand_idx)*WRENW +: WRENW];
    assign rd_addr_sel = rd_addr_in[int'(rd_cand_idx)*ADDRW +: ADDRW];

    // Credits come only from registered state so rsp_ready_in never reaches the read grant.
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok   = credit_used < (CNTW+1)'(RSP_DEPTH);

    assign wr_fire = run && wr_cand_valid;
    assign hazard  = wr_fire && (rd_addr_sel == wr_addr_sel);
    assign rd_fire = run && rd_cand_valid && credit_ok && !hazard;

    assign wr_ready_out = wr_fire ? (NUM_REQS'(1) << wr_cand_idx) : '0;
    assign rd_ready_out = rd_fire ? (NUM_REQS'(1) << rd_cand_idx) : '0;

    always_comb begin
        ram_write = 1'b0;
        ram_wren  = '0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (state == ST_CLEAR && !reset) begin
            ram_write = 1'b1;
            ram_wren  = '1;
            ram_waddr = clear_cnt;
            ram_wdata = CLEAR_VALUE;
        end else if (wr_fire) begin
            ram_write = 1'b1;
            ram_wren  = wr_wren_sel;
            ram_waddr = wr_addr_sel;
            ram_wdata = wr_data_sel;
        end
    end

    assign ram_read  = rd_fire;
    assign ram_raddr = rd_addr_sel;

    generate
        if (OUT_REG == 0) begin : g_async
            assign push_valid = rd_fire;
            assign push_idx   = rd_cand_idx;
        end else begin : g_line
            logic [OUT_REG-1:0]  line_valid;
            logic [REQ_SELW-1:0] line_idx [OUT_REG];

            // Requester indices ride alongside the RAM's registered read latency.
            always_ff @(posedge clk) begin
                if (reset) begin
                    line_valid <= '0;
                end else begin
                    for (int k = OUT_REG - 1; k > 0; k--) begin
                        line_valid[k] <= line_valid[k-1];
                    end
                    line_valid[0] <= rd_fire;
                end
                for (int k = OUT_REG - 1; k > 0; k--) begin
                    line_idx[k] <= line_idx[k-1];
                end
                line_idx[0] <= rd_cand_idx;
            end

            assign push_valid = line_valid[OUT_REG-1];
            assign push_idx   = line_idx[OUT_REG-1];
        end
    endgenerate

    assign rsp_valid_out = (fifo_count != '0);
    assign rsp_data_out  = fifo_data[fifo_rd_ptr];
    assign rsp_idx_out   = fifo_idx[fifo_rd_ptr];
    assign pop           = rsp_valid_out && rsp_ready_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight    <= '0;
            fifo_count  <= '0;
            fifo_rd_ptr <= '0;
            fifo_wr_ptr <= '0;
        end else begin
            inflight   <= inflight + CNTW'(rd_fire) - CNTW'(push_valid);
            fifo_count <= fifo_count + CNTW'(push_valid) - CNTW'(pop);
            if (push_valid) begin
                fifo_wr_ptr <= (fifo_wr_ptr == FIFO_AW'(RSP_DEPTH - 1)) ? '0 : fifo_wr_ptr + 1'b1;
            end
            if (pop) begin
                fifo_rd_ptr <= (fifo_rd_ptr == FIFO_AW'(RSP_DEPTH - 1)) ? '0 : fifo_rd_ptr + 1'b1;
            end
        end
        if (push_valid) begin
            fifo_data[fifo_wr_ptr] <= ram_rdata;
            fifo_idx[fifo_wr_ptr]  <= push_idx;
        end
    end

`ifdef VX_DP_RAM_ARB_PERF_EN
    logic wr_stall;
    logic rd_stall;

    assign wr_stall = run && (|wr_valid_in) && !wr_fire;
    assign rd_stall = run && (|rd_valid_in) && !rd_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_wr_stalls_out <= '0;
            perf_rd_stalls_out <= '0;
        end else begin
            if (wr_stall && perf_wr_stalls_out != '1) begin
                perf_wr_stalls_out <= perf_wr_stalls_out + 1'b1;
            end
            if (rd_stall && perf_rd_stalls_out != '1) begin
                perf_rd_stalls_out <= perf_rd_stalls_out + 1'b1;
            end
        end
    end
`endif

endmodule
